// File: rtl/jtpang_eeprom_pkg.sv
// Shared types and opcode constants for the 93C46-style serial EEPROM emulator.
package jtpang_eeprom_pkg;

  localparam int AW = 6;   // 64 words
  localparam int DW = 16;  // 16-bit words

  localparam logic [DW-1:0] ERASED = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD,
    WD,
    FILL,
    BUSY,
    DONE
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] OP_EXT   = 2'b00;

  localparam logic [1:0] EXT_EWEN = 2'b11;
  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_WRAL = 2'b01;

endpackage

// File: rtl/jtpang_eeprom_mem.sv
// 64x16 dual-port storage: port A is the 16-bit serial side, port B the
// byte-wide dump/restore side with a registered read.
module jtpang_eeprom_mem
  import jtpang_eeprom_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic [AW:0]   b_addr,
  input  logic          b_we,
  input  logic [7:0]    b_din,
  output logic [7:0]    b_dout
);

  logic [7:0] mem_lo [1<<AW];
  logic [7:0] mem_hi [1<<AW];

  logic [AW-1:0] b_word;
  assign b_word = b_addr[AW:1];

  // NOTE: the arrays carry no reset so they map onto RAM and keep their
  // contents across rst; only the registered dump output is reset.
  // The port B write comes last so a same-word collision lets the restore
  // byte win while port A still updates the other byte.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_lo[a_addr] <= a_din[7:0];
      mem_hi[a_addr] <= a_din[15:8];
    end
    if (b_we) begin
      if (b_addr[0]) mem_hi[b_word] <= b_din;
      else           mem_lo[b_word] <= b_din;
    end
    a_dout <= {mem_hi[a_addr], mem_lo[a_addr]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) b_dout <= '0;
    else     b_dout <= b_addr[0] ? mem_hi[b_word] : mem_lo[b_word];
  end

endmodule

// File: rtl/jtpang_eeprom.sv
// 93C46-compatible serial EEPROM emulator: bit-banged command decoder in
// front of a 64x16 RAM that can also be dumped/restored byte-wise.
module jtpang_eeprom
  import jtpang_eeprom_pkg::*;
#(
  parameter int BUSY_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       sdi,
  output logic       sdo,
  input  logic [6:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       prog_we,
  output logic [7:0] prog_din
);

  localparam int CW = $clog2(BUSY_CYC + 1);

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] sreg_q, sreg_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wral_q, wral_d;
  logic          wen_q, wen_d;
  logic [CW-1:0] busy_q, busy_d;
  logic          sdo_q, sdo_d;
  logic          sclk_s, sclk_l;

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_dout;

  logic          sclk_rise;
  logic [7:0]    cmd_byte;
  logic [DW-1:0] data_word;

  assign sclk_rise = sclk_s & ~sclk_l;
  assign cmd_byte  = {sreg_q[6:0], sdi};
  assign data_word = {sreg_q[DW-2:0], sdi};
  assign sdo       = sdo_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      addr_q    <= '0;
      wral_q    <= 1'b0;
      wen_q     <= 1'b0;
      busy_q    <= '0;
      sdo_q     <= 1'b1;
      sclk_s    <= 1'b0;
      sclk_l    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      addr_q    <= addr_d;
      wral_q    <= wral_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
      sdo_q     <= sdo_d;
      sclk_s    <= sclk;
      sclk_l    <= sclk_s;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    addr_d    = addr_q;
    wral_d    = wral_q;
    wen_d     = wen_q;
    busy_d    = busy_q;
    sdo_d     = sdo_q;
    mem_we    = 1'b0;
    mem_wa    = addr_q;
    mem_wd    = sreg_q;

    // Dropping cs aborts everything except the self-timed busy countdown
    if (!cs && state_q != BUSY) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sdo_d     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sdo_d = 1'b1;
          if (sclk_rise && sdi) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end

        CMD: if (sclk_rise) begin
          sreg_d    = data_word;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            addr_d    = cmd_byte[5:0];
            wral_d    = 1'b0;
            state_d   = DONE;
            case (cmd_byte[7:6])
              OP_READ: begin
                state_d = RD;
                sdo_d   = 1'b0;
              end
              OP_WRITE: state_d = WD;
              OP_ERASE: if (wen_q) begin
                mem_we  = 1'b1;
                mem_wa  = cmd_byte[5:0];
                mem_wd  = ERASED;
                state_d = BUSY;
                busy_d  = CW'(BUSY_CYC);
                sdo_d   = 1'b0;
              end
              default: begin
                case (cmd_byte[5:4])
                  EXT_EWEN: wen_d = 1'b1;
                  EXT_EWDS: wen_d = 1'b0;
                  EXT_ERAL: if (wen_q) begin
                    sreg_d  = ERASED;
                    addr_d  = '0;
                    state_d = FILL;
                    sdo_d   = 1'b0;
                  end
                  EXT_WRAL: begin
                    wral_d  = 1'b1;
                    state_d = WD;
                  end
                endcase
              end
            endcase
          end
        end

        // The word at addr_q was fetched when addr_q last changed
        RD: if (sclk_rise) begin
          sdo_d     = mem_dout[~bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) addr_d = addr_q + 6'd1;
        end

        WD: if (sclk_rise) begin
          sreg_d    = data_word;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            if (!wen_q) begin
              state_d = DONE;
            end else if (wral_q) begin
              addr_d  = '0;
              state_d = FILL;
              sdo_d   = 1'b0;
            end else begin
              mem_we  = 1'b1;
              mem_wd  = data_word;
              state_d = BUSY;
              busy_d  = CW'(BUSY_CYC);
              sdo_d   = 1'b0;
            end
          end
        end

        FILL: begin
          mem_we = 1'b1;
          addr_d = addr_q + 6'd1;
          sdo_d  = 1'b0;
          if (addr_q == 6'd63) begin
            state_d = BUSY;
            busy_d  = CW'(BUSY_CYC);
          end
        end

        BUSY: begin
          if (busy_q == '0) begin
            state_d = DONE;
            sdo_d   = 1'b1;
          end else begin
            busy_d = busy_q - 1'b1;
            sdo_d  = ~cs;
          end
        end

        default: sdo_d = 1'b1;  // DONE
      endcase
    end
  end

  jtpang_eeprom_mem u_mem (
    .clk    (clk),
    .rst    (rst),
    .a_addr (mem_wa),
    .a_we   (mem_we),
    .a_din  (mem_wd),
    .a_dout (mem_dout),
    .b_addr (prog_addr),
    .b_we   (prog_we),
    .b_din  (prog_data),
    .b_dout (prog_din)
  );

endmodule

// File: tb/tb_jtpang_eeprom.sv
// Self-checking bench for jtpang_eeprom: a table of serial operations with
// read-back, plus hand-written multi-cycle sequences.
module tb_jtpang_eeprom;
  import jtpang_eeprom_pkg::*;

  localparam int BUSY_CYC = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       sclk = 1'b0;
  logic       sdi = 1'b0;
  logic       sdo;
  logic [6:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       prog_we = 1'b0;
  logic [7:0] prog_din;

  int n_cmp = 0;
  int n_err = 0;

  jtpang_eeprom #(.BUSY_CYC(BUSY_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .sclk      (sclk),
    .sdi       (sdi),
    .sdo       (sdo),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we),
    .prog_din  (prog_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // One serial bit; returns sdo sampled 4 clk after the rising sclk.
  task automatic send_bit(input logic b, output logic o);
    @(negedge clk);
    sdi  = b;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    o = sdo;
  endtask

  // Counts clk cycles with sdo low until it returns high, bounded by budget.
  task automatic wait_ready(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sdo === 1'b1) break;
      n++;
    end
  endtask

  task automatic end_xfer();
    @(negedge clk);
    sclk = 1'b0;
    cs   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Leading zero, start bit, then op/addr MSB first; o = sdo after last bit.
  task automatic cmd(input logic [1:0] op, input logic [5:0] a, output logic o);
    logic       d;
    logic [7:0] byte_v;
    byte_v = {op, a};
    @(negedge clk);
    cs   = 1'b0;
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    send_bit(1'b0, d);
    send_bit(1'b1, d);
    for (int i = 7; i >= 0; i--) send_bit(byte_v[i], o);
  endtask

  task automatic send_word(input logic [15:0] w, output logic o);
    for (int i = 15; i >= 0; i--) send_bit(w[i], o);
  endtask

  task automatic recv_word(output logic [15:0] w);
    logic b;
    for (int i = 15; i >= 0; i--) begin
      send_bit(1'b0, b);
      w[i] = b;
    end
  endtask

  task automatic ext(input logic [1:0] e);
    logic o;
    cmd(OP_EXT, {e, 4'h0}, o);
    end_xfer();
  endtask

  // low = clk cycles sdo stayed low after the final bit (0 if never low).
  task automatic write_word(input logic [5:0] a, input logic [15:0] w, output int low);
    logic o;
    int   n;
    cmd(OP_WRITE, a, o);
    send_word(w, o);
    low = 0;
    if (o === 1'b0) begin
      wait_ready(400, n);
      low = n + 3;
    end
    end_xfer();
  endtask

  task automatic erase_word(input logic [5:0] a);
    logic o;
    int   n;
    cmd(OP_ERASE, a, o);
    if (o === 1'b0) wait_ready(400, n);
    end_xfer();
  endtask

  task automatic read_word(input logic [5:0] a, output logic [15:0] w, output logic dummy);
    cmd(OP_READ, a, dummy);
    recv_word(w);
    end_xfer();
  endtask

  task automatic prog_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  typedef enum logic [2:0] {K_EWEN, K_EWDS, K_WRITE, K_ERASE, K_RESTORE} kind_t;
  typedef struct {
    kind_t       kind;
    logic [5:0]  addr;
    logic [15:0] data;
    bit          chk;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    logic        dm;
    logic        o;
    int          low;
    int          n;

    tbl[0]  = '{K_EWEN,    6'd0,  16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{K_WRITE,   6'd5,  16'h1234, 1'b1, 16'h1234};
    tbl[2]  = '{K_WRITE,   6'd63, 16'hA5C3, 1'b1, 16'hA5C3};
    tbl[3]  = '{K_ERASE,   6'd63, 16'h0000, 1'b1, 16'hFFFF};
    tbl[4]  = '{K_WRITE,   6'd0,  16'h8001, 1'b1, 16'h8001};
    tbl[5]  = '{K_EWDS,    6'd0,  16'h0000, 1'b1, 16'h8001};
    tbl[6]  = '{K_WRITE,   6'd0,  16'h5555, 1'b1, 16'h8001};
    tbl[7]  = '{K_ERASE,   6'd0,  16'h0000, 1'b1, 16'h8001};
    tbl[8]  = '{K_RESTORE, 6'd20, 16'h5AA5, 1'b1, 16'h5AA5};
    tbl[9]  = '{K_EWEN,    6'd0,  16'h0000, 1'b0, 16'h0000};
    tbl[10] = '{K_WRITE,   6'd62, 16'h0000, 1'b1, 16'h0000};
    tbl[11] = '{K_WRITE,   6'd62, 16'hC3A5, 1'b1, 16'hC3A5};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sdo", {15'd0, sdo}, 16'h0001);
    check("rst_prog_din", {8'd0, prog_din}, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_sdo", {15'd0, sdo}, 16'h0001);

    for (int i = 0; i < 12; i++) begin
      case (tbl[i].kind)
        K_EWEN:    ext(EXT_EWEN);
        K_EWDS:    ext(EXT_EWDS);
        K_WRITE:   write_word(tbl[i].addr, tbl[i].data, low);
        K_ERASE:   erase_word(tbl[i].addr);
        default: begin
          prog_write({tbl[i].addr, 1'b0}, tbl[i].data[7:0]);
          prog_write({tbl[i].addr, 1'b1}, tbl[i].data[15:8]);
        end
      endcase
      if (tbl[i].chk) begin
        read_word(tbl[i].addr, w, dm);
        check($sformatf("vec%0d_word", i), w, tbl[i].exp);
      end
    end

    // Write with busy timing, then read back with dummy bit
    write_word(6'd5, 16'h1234, low);
    check_range("write_busy_len", low, BUSY_CYC, BUSY_CYC + 2);
    read_word(6'd5, w, dm);
    check("read_dummy", {15'd0, dm}, 16'h0000);
    check("read_addr5", w, 16'h1234);

    // Reset clears wen: write is refused and sdo never drops
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst2_sdo", {15'd0, sdo}, 16'h0001);
    write_word(6'd5, 16'h5555, low);
    check("wen_off_busy", low[15:0], 16'h0000);
    read_word(6'd5, w, dm);
    check("wen_off_word", w, 16'h1234);

    // Restore bytes, read serially, then dump
    prog_write(7'h0A, 8'hCD);
    prog_write(7'h0B, 8'hAB);
    read_word(6'd5, w, dm);
    check("restore_word", w, 16'hABCD);
    @(negedge clk); prog_addr = 7'h0B;
    @(negedge clk);
    check("dump_hi", {8'd0, prog_din}, 16'h00AB);
    prog_addr = 7'h0A;
    @(negedge clk);
    check("dump_lo", {8'd0, prog_din}, 16'h00CD);

    // cs dropped mid data: nothing committed, back to IDLE
    prog_write(7'h0E, 8'h11);
    prog_write(7'h0F, 8'h11);
    ext(EXT_EWEN);
    cmd(OP_WRITE, 6'd7, o);
    for (int i = 0; i < 10; i++) send_bit(1'b0, o);
    @(negedge clk); cs = 1'b0; sclk = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_sdo", {15'd0, sdo}, 16'h0001);
    read_word(6'd7, w, dm);
    check("abort_word", w, 16'h1111);
    write_word(6'd7, 16'h7777, low);
    read_word(6'd7, w, dm);
    check("after_abort_word", w, 16'h7777);

    // WRAL fill + busy, then streaming read across the wrap
    cmd(OP_EXT, {EXT_WRAL, 4'h0}, o);
    send_word(16'h00FF, o);
    check("wral_busy_start", {15'd0, o}, 16'h0000);
    wait_ready(400, n);
    check_range("wral_busy_len", n + 3, 64 + BUSY_CYC, 64 + BUSY_CYC + 2);
    end_xfer();
    prog_write(7'h00, 8'hEF);
    prog_write(7'h01, 8'hBE);
    cmd(OP_READ, 6'd0, dm);
    check("seq_dummy", {15'd0, dm}, 16'h0000);
    for (int k = 0; k < 65; k++) begin
      recv_word(w);
      check($sformatf("seq_word%0d", k), w, (k % 64 == 0) ? 16'hBEEF : 16'h00FF);
    end
    end_xfer();

    // Reset while busy: committed word kept, wen cleared
    cmd(OP_WRITE, 6'd9, o);
    send_word(16'h9999, o);
    repeat (10) @(negedge clk);
    check("busy_before_rst", {15'd0, sdo}, 16'h0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("busy_rst_sdo", {15'd0, sdo}, 16'h0001);
    end_xfer();
    write_word(6'd9, 16'h0000, low);
    check("busy_rst_wen", low[15:0], 16'h0000);
    read_word(6'd9, w, dm);
    check("busy_rst_word", w, 16'h9999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
